counter_mod10: RTL and testbench



---
 rtl/counter_mod10_pkg.sv | 12 +
 rtl/counter_mod10.sv | 56 +++++
 tb/tb_counter_mod10.sv | 118 +++++++++++
 3 files changed

// File: rtl/counter_mod10_pkg.sv
// rtl/counter_mod10_pkg.sv - shared timer digit constants and types
package counter_mod10_pkg;

    localparam int TIMER_MODULUS = 10;
    localparam int TIMER_WIDTH   = 4;

    typedef logic [TIMER_WIDTH-1:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_MAX  = bcd_digit_t'(TIMER_MODULUS - 1);
    localparam bcd_digit_t DIGIT_ZERO = bcd_digit_t'(0);

endpackage

// File: rtl/counter_mod10.sv
// rtl/counter_mod10.sv - single BCD down-counter digit with load, wrap and borrow
module counter_mod10
    import counter_mod10_pkg::*;
#(
    parameter int MODULUS = TIMER_MODULUS,
    parameter int WIDTH   = TIMER_WIDTH
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic             loadn,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] ones,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;

    logic [WIDTH-1:0] ones_q;
    logic [WIDTH-1:0] ones_d;
    logic             at_zero;

    assign at_zero = (ones_q == ZERO_VAL);

    // Next digit: load (saturated to the top digit) beats count-down; an
    // out-of-range digit is steered back to the top digit.
    always_comb begin
        ones_d = (ones_q > MAX_VAL) ? MAX_VAL : ones_q;
        if (!loadn) begin
            ones_d = (data > MAX_VAL) ? MAX_VAL : data;
        end else if (enable) begin
            if (at_zero || (ones_q > MAX_VAL)) begin
                ones_d = MAX_VAL;
            end else begin
                ones_d = ones_q - WIDTH'(1);
            end
        end
    end

    // Digit register; clear has priority over everything else.
    always_ff @(posedge clock) begin
        if (!clrn) begin
            ones_q <= ZERO_VAL;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones = ones_q;
    assign zero = at_zero;
    // Borrow is only raised when this edge will actually wrap 0 -> max.
    assign tc   = clrn & loadn & enable & at_zero;

endmodule

// File: tb/tb_counter_mod10.sv
// tb/tb_counter_mod10.sv - randomized and directed check of counter_mod10 against a digit model
module tb_counter_mod10;

    logic       clock;
    logic       clrn;
    logic       loadn;
    logic       enable;
    logic [3:0] data;
    logic [3:0] ones;
    logic       tc;
    logic       zero;

    int checks;
    int errors;
    int model;

    counter_mod10 dut (
        .clock  (clock),
        .clrn   (clrn),
        .loadn  (loadn),
        .enable (enable),
        .data   (data),
        .ones   (ones),
        .tc     (tc),
        .zero   (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_ones;
        logic [3:0] exp_zero;
        logic [3:0] exp_tc;
        exp_ones = 4'(model);
        exp_zero = {3'b000, model == 0};
        exp_tc   = {3'b000, clrn && loadn && enable && (model == 0)};
        chk({tag, "_ones"}, ones, exp_ones);
        chk({tag, "_zero"}, {3'b000, zero}, exp_zero);
        chk({tag, "_tc"}, {3'b000, tc}, exp_tc);
    endtask

    // Drive one cycle of inputs, check the present outputs, then advance the model over the edge.
    task automatic step(input string tag, input logic c, input logic l, input logic e, input logic [3:0] d);
        clrn   = c;
        loadn  = l;
        enable = e;
        data   = d;
        #1;
        check_outputs(tag);
        @(posedge clock);
        if (!c)
            model = 0;
        else if (!l)
            model = (int'(d) > 9) ? 9 : int'(d);
        else if (e)
            model = (model + 9) % 10;
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = 0;
        clrn   = 1'b0;
        loadn  = 1'b1;
        enable = 1'b1;
        data   = 4'd0;
        @(posedge clock);
        @(negedge clock);

        step("reset", 1'b0, 1'b1, 1'b1, 4'd5);
        step("reset_hold", 1'b1, 1'b0, 1'b1, 4'd9);
        step("load9", 1'b1, 1'b0, 1'b1, 4'd3);
        step("load3", 1'b1, 1'b0, 1'b0, 4'd2);
        step("load2", 1'b1, 1'b0, 1'b1, 4'd2);
        for (int i = 0; i < 14; i++)
            step("count", 1'b1, 1'b1, 1'b1, 4'd7);

        step("load1", 1'b1, 1'b0, 1'b0, 4'd1);
        step("to_zero", 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++)
            step("hold_zero", 1'b1, 1'b1, 1'b0, 4'd0);
        step("wrap", 1'b1, 1'b1, 1'b1, 4'd0);

        for (int i = 0; i < 3; i++)
            step("count2", 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++)
            step("clr_held", 1'b0, 1'b1, 1'b1, 4'd0);

        for (int v = 10; v < 16; v++)
            step("saturate", 1'b1, 1'b0, 1'b1, 4'(v));
        step("clr_vs_load", 1'b0, 1'b0, 1'b1, 4'd7);
        step("after_clr", 1'b1, 1'b1, 1'b0, 4'd0);

        for (int i = 0; i < 300; i++)
            step("rand", ($urandom % 8) != 0, ($urandom % 5) != 0,
                 $urandom % 2 == 1, 4'($urandom));

        clrn = 1'b1;
        loadn = 1'b1;
        enable = 1'b1;
        #1;
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
